// File: rtl/fpu_ctrl_div_sqrt_if.sv
// Handshake and control bundle between the requester/datapath and the div/sqrt controller.
interface fpu_ctrl_div_sqrt_if #(
  parameter int unsigned C_PREC_W = 6
);
  logic                Div_start_SI;
  logic                Sqrt_start_SI;
  logic [C_PREC_W-1:0] Precision_ctl_SI;
  logic [2:0]          RM_SI;
  logic                Special_SI;
  logic                Kill_SI;
  logic                Out_ready_SI;
  logic                Ready_SO;
  logic                Load_SO;
  logic                Iter_en_SO;
  logic [3:0]          Iter_cnt_DO;
  logic                Norm_en_SO;
  logic                Div_sel_SO;
  logic                Sqrt_sel_SO;
  logic [2:0]          RM_DO;
  logic                Out_valid_SO;
  logic                Busy_SO;

  modport master (
    output Div_start_SI, Sqrt_start_SI, Precision_ctl_SI, RM_SI, Special_SI,
           Kill_SI, Out_ready_SI,
    input  Ready_SO, Load_SO, Iter_en_SO, Iter_cnt_DO, Norm_en_SO, Div_sel_SO,
           Sqrt_sel_SO, RM_DO, Out_valid_SO, Busy_SO
  );

  modport slave (
    input  Div_start_SI, Sqrt_start_SI, Precision_ctl_SI, RM_SI, Special_SI,
           Kill_SI, Out_ready_SI,
    output Ready_SO, Load_SO, Iter_en_SO, Iter_cnt_DO, Norm_en_SO, Div_sel_SO,
           Sqrt_sel_SO, RM_DO, Out_valid_SO, Busy_SO
  );
endinterface

// File: rtl/fpu_ctrl_div_sqrt.sv
// Sequencing controller for an iterative FP divide/square-root datapath.
// Optional: FPU_DIV_SQRT_SPECIAL_BYPASS_EN sends special operands straight to NORM.
module fpu_ctrl_div_sqrt #(
  parameter int unsigned C_PREC_W   = 6,
  parameter int unsigned C_ITER_MAX = 13
) (
  input logic                 Clk_CI,
  input logic                 Rst_RI,
  fpu_ctrl_div_sqrt_if.slave  io
);

  typedef enum logic [1:0] {IDLE, ITER, NORM, HOLD} state_e;

  state_e     state_q, state_d;
  logic       accept;
  logic [4:0] prec_eff;
  logic [3:0] n_d, n_q;
  logic [3:0] cnt_q;
  logic       div_sel_q, sqrt_sel_q;
  logic [2:0] rm_q;

  assign accept = (state_q == IDLE) & (io.Div_start_SI | io.Sqrt_start_SI) & ~io.Kill_SI;

  // Zero or out-of-range precision requests fall back to full 23-bit mantissa.
  always_comb begin
    if (io.Precision_ctl_SI == '0 || io.Precision_ctl_SI > C_PREC_W'(23))
      prec_eff = 5'd23;
    else
      prec_eff = 5'(io.Precision_ctl_SI);
    n_d = 4'((prec_eff + 5'd4) >> 1);
    if (n_d > 4'(C_ITER_MAX))
      n_d = 4'(C_ITER_MAX);
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef FPU_DIV_SQRT_SPECIAL_BYPASS_EN
          state_d = io.Special_SI ? NORM : ITER;
`else
          state_d = ITER;
`endif
        end
      end
      ITER: begin
        if (io.Kill_SI)
          state_d = IDLE;
        else if (cnt_q == n_q - 4'd1)
          state_d = NORM;
      end
      NORM: state_d = io.Kill_SI ? IDLE : HOLD;
      HOLD: begin
        if (io.Kill_SI || io.Out_ready_SI)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.Ready_SO     = (state_q == IDLE);
    io.Busy_SO      = (state_q != IDLE);
    io.Load_SO      = accept;
    io.Iter_en_SO   = (state_q == ITER);
    io.Norm_en_SO   = (state_q == NORM);
    io.Out_valid_SO = (state_q == HOLD);
    io.Iter_cnt_DO  = cnt_q;
    io.Div_sel_SO   = div_sel_q;
    io.Sqrt_sel_SO  = sqrt_sel_q;
    io.RM_DO        = rm_q;
  end

  // Counter tracks the next state so it reads zero in every non-ITER cycle.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      cnt_q      <= '0;
      n_q        <= '0;
      div_sel_q  <= 1'b0;
      sqrt_sel_q <= 1'b0;
      rm_q       <= '0;
    end else begin
      if (state_q == ITER && state_d == ITER)
        cnt_q <= cnt_q + 4'd1;
      else
        cnt_q <= '0;

      if (state_q != IDLE && io.Kill_SI) begin
        div_sel_q  <= 1'b0;
        sqrt_sel_q <= 1'b0;
        rm_q       <= '0;
      end else if (accept) begin
        div_sel_q  <= io.Div_start_SI;
        sqrt_sel_q <= ~io.Div_start_SI;
        rm_q       <= io.RM_SI;
        n_q        <= n_d;
      end
    end
  end

endmodule
